comet_ii_mem_sys: RTL and testbench

COMET_II_MEM_SYS -- requirements
Module: comet_ii_mem_sys

---
 rtl/comet_ii_pkg.sv | 16 +
 rtl/comet_ii_ce_gen.sv | 35 +++
 rtl/comet_ii_mem_sys.sv | 140 ++++++++++++++
 tb/tb_comet_ii_mem_sys.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/comet_ii_pkg.sv
// Shared definitions for the COMET-II memory subsystem: boot states,
// IO register offsets and default bus widths.
package comet_ii_pkg;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } boot_state_e;

  localparam int IO_OFF_GPIO_IN  = 0;
  localparam int IO_OFF_GPIO_OUT = 1;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 16;

endpackage

// File: rtl/comet_ii_ce_gen.sv
// CPU clock-enable generator: one-mclk ce pulse every DIV_N+1 mclk cycles.
// With DIV_N=0 the counter never advances and ce stays high after reset.
module comet_ii_ce_gen #(
  parameter int DIV_N = 1
) (
  input  logic mclk,
  input  logic rst,
  output logic ce
);

  localparam int CW = (DIV_N > 0) ? $clog2(DIV_N + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ce_q, ce_d;

  // Count mclk cycles and flag the wrap cycle as the next ce pulse.
  always_comb begin
    ce_d  = (cnt_q == CW'(DIV_N));
    cnt_d = ce_d ? '0 : cnt_q + CW'(1);
  end

  // Divider state with synchronous reset.
  always_ff @(posedge mclk) begin
    if (rst) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/comet_ii_mem_sys.sv
// COMET-II memory subsystem: ce divider, boot sequencer, word RAM and a
// two-register GPIO block behind one read port and one write port.
// Optional macro COMET_MEM_SYS_WRPROT_EN drops RAM writes below PROT_TOP.
module comet_ii_mem_sys
  import comet_ii_pkg::*;
#(
  parameter int          DATA_W      = DEFAULT_DATA_W,
  parameter int          ADDR_W      = DEFAULT_ADDR_W,
  parameter int          DEPTH       = 256,
  parameter int          DIV_N       = 1,
  parameter int          INIT_CYCLES = 4,
  parameter int unsigned IO_BASE     = 32'h0000_FF00,
  parameter int          N_GPIO      = 8,
  parameter int unsigned PROT_TOP    = 32'h0000_0050
) (
  input  logic              mclk,
  input  logic              rst,
  output logic              ce,
  output logic              cpu_init,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [N_GPIO-1:0] gpio_in,
  output logic [N_GPIO-1:0] gpio_out,
  output logic              bus_err
);

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ICW    = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;
  localparam logic [ADDR_W-1:0] GPIO_IN_ADDR  = ADDR_W'(IO_BASE + IO_OFF_GPIO_IN);
  localparam logic [ADDR_W-1:0] GPIO_OUT_ADDR = ADDR_W'(IO_BASE + IO_OFF_GPIO_OUT);

  boot_state_e       state_q, state_d;
  logic [ICW-1:0]    init_cnt_q, init_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [N_GPIO-1:0] gpio_out_q, gpio_out_d;
  logic              bus_err_q, bus_err_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              acc;
  logic              rd_in_ram, wr_in_ram;
  logic              wr_prot;
  logic              ram_we;

  comet_ii_ce_gen #(.DIV_N(DIV_N)) u_ce_gen (
    .mclk (mclk),
    .rst  (rst),
    .ce   (ce)
  );

`ifdef COMET_MEM_SYS_WRPROT_EN
  assign wr_prot = ({1'b0, waddr} < (ADDR_W+1)'(PROT_TOP));
`else
  // PROT_TOP has no effect when write protection is not built in.
  assign wr_prot = 1'b0 & (PROT_TOP != 0);
`endif

  // Boot sequencing plus read/write decode; reads use pre-edge state so a
  // same-edge write to the same location is seen only by the next read.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rdata_d    = rdata_q;
    gpio_out_d = gpio_out_q;
    bus_err_d  = bus_err_q;
    ram_we     = 1'b0;

    acc       = ce && (state_q == ST_RUN);
    rd_in_ram = ({1'b0, raddr} < (ADDR_W+1)'(DEPTH));
    wr_in_ram = ({1'b0, waddr} < (ADDR_W+1)'(DEPTH));

    if (state_q == ST_HOLD && ce) begin
      if (init_cnt_q == ICW'(INIT_CYCLES - 1)) begin
        state_d = ST_RUN;
      end else begin
        init_cnt_d = init_cnt_q + ICW'(1);
      end
    end

    if (acc && re) begin
      if (rd_in_ram) begin
        rdata_d = mem[raddr[RAM_AW-1:0]];
      end else if (raddr == GPIO_IN_ADDR) begin
        rdata_d = DATA_W'(gpio_in);
      end else if (raddr == GPIO_OUT_ADDR) begin
        rdata_d = DATA_W'(gpio_out_q);
      end else begin
        rdata_d   = '0;
        bus_err_d = 1'b1;
      end
    end

    if (acc && we) begin
      if (wr_in_ram) begin
        if (wr_prot) begin
          bus_err_d = 1'b1;
        end else begin
          ram_we = !rst;
        end
      end else if (waddr == GPIO_OUT_ADDR) begin
        gpio_out_d = wdata[N_GPIO-1:0];
      end else begin
        bus_err_d = 1'b1;
      end
    end
  end

  // Control and output registers; reset wins over any same-edge access.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q    <= ST_HOLD;
      init_cnt_q <= '0;
      rdata_q    <= '0;
      gpio_out_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rdata_q    <= rdata_d;
      gpio_out_q <= gpio_out_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // RAM array keeps its contents across reset.
  always_ff @(posedge mclk) begin
    if (ram_we) begin
      mem[waddr[RAM_AW-1:0]] <= wdata;
    end
  end

  assign cpu_init = (state_q == ST_HOLD);
  assign rdata    = rdata_q;
  assign gpio_out = gpio_out_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_comet_ii_mem_sys.sv
// Self-checking bench for comet_ii_mem_sys: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_comet_ii_mem_sys;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int DEPTH       = 256;
  localparam int DIV_N       = 1;
  localparam int INIT_CYCLES = 4;
  localparam int N_GPIO      = 8;
  localparam logic [15:0] IO_IN  = 16'hFF00;
  localparam logic [15:0] IO_OUT = 16'hFF01;
  localparam int PROT_TOP_I  = 'h50;
`ifdef COMET_MEM_SYS_WRPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic              mclk = 1'b0;
  logic              rst = 1'b1;
  logic              ce, cpu_init;
  logic              re = 1'b0;
  logic [ADDR_W-1:0] raddr = '0;
  logic [DATA_W-1:0] rdata;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] waddr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [N_GPIO-1:0] gpio_in = '0;
  logic [N_GPIO-1:0] gpio_out;
  logic              bus_err;

  // Behavioural model state: edges since reset, ce pulses seen, registers, RAM.
  int          edgeCount;
  int          pulses;
  bit          mCe;
  logic [15:0] mRdata;
  bit          mRdKnown;
  logic [7:0]  mGpio;
  bit          mErr;
  logic [15:0] mMem [DEPTH];
  bit          mValid [DEPTH];

  int total = 0;
  int bad   = 0;

  comet_ii_mem_sys #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DIV_N(DIV_N),
    .INIT_CYCLES(INIT_CYCLES), .IO_BASE(32'hFF00), .N_GPIO(N_GPIO),
    .PROT_TOP(32'h50)
  ) dut (
    .mclk(mclk), .rst(rst), .ce(ce), .cpu_init(cpu_init),
    .re(re), .raddr(raddr), .rdata(rdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .bus_err(bus_err)
  );

  always #5 mclk = ~mclk;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one mclk cycle of inputs, advance the model, then check all outputs.
  task automatic applyStimulus(input bit sRst, input bit sRe, input logic [15:0] sRaddr,
                               input bit sWe, input logic [15:0] sWaddr,
                               input logic [15:0] sWdata, input logic [7:0] sGin);
    bit         access;
    logic [7:0] oldGpio;
    rst = sRst; re = sRe; raddr = sRaddr; we = sWe; waddr = sWaddr;
    wdata = sWdata; gpio_in = sGin;
    access  = mCe && (pulses >= INIT_CYCLES);
    oldGpio = mGpio;
    if (sRst) begin
      edgeCount = 0; pulses = 0; mCe = 0;
      mRdata = 16'h0; mRdKnown = 1; mGpio = 8'h0; mErr = 0;
    end else begin
      if (access && sRe) begin
        mRdKnown = 1;
        if (sRaddr < DEPTH) begin
          mRdata = mMem[sRaddr]; mRdKnown = mValid[sRaddr];
        end else if (sRaddr == IO_IN) mRdata = {8'h00, sGin};
        else if (sRaddr == IO_OUT) mRdata = {8'h00, oldGpio};
        else begin mRdata = 16'h0; mErr = 1; end
      end
      if (access && sWe) begin
        if (sWaddr < DEPTH) begin
          if (PROT && sWaddr < PROT_TOP_I) mErr = 1;
          else begin mMem[sWaddr] = sWdata; mValid[sWaddr] = 1; end
        end else if (sWaddr == IO_OUT) mGpio = sWdata[7:0];
        else mErr = 1;
      end
      if (mCe) pulses++;
      edgeCount++;
      mCe = (edgeCount % (DIV_N + 1) == 0);
    end
    @(posedge mclk);
    #1;
    checkOutput("ce", ce, mCe);
    checkOutput("cpu_init", cpu_init, (pulses < INIT_CYCLES));
    if (mRdKnown) checkOutput("rdata", rdata, mRdata);
    checkOutput("gpio_out", gpio_out, mGpio);
    checkOutput("bus_err", bus_err, mErr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 8'($urandom));
  endtask

  // Idle until the next cycle in which an access will be sampled (bounded).
  task automatic waitAccess();
    for (int i = 0; i < 32 && !(mCe && pulses >= INIT_CYCLES); i++) idle(1);
    checkOutput("wait_ce", ce, 1);
    checkOutput("wait_run", cpu_init, 0);
  endtask

  task automatic doWrite(input logic [15:0] a, input logic [15:0] d);
    waitAccess();
    applyStimulus(0, 0, 0, 1, a, d, 8'($urandom));
  endtask

  task automatic doRead(input logic [15:0] a, input logic [7:0] gin);
    waitAccess();
    applyStimulus(0, 1, a, 0, 0, 0, gin);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 8'h00);
  endtask

  function automatic logic [15:0] randAddr();
    case ($urandom_range(0, 9))
      0:       return IO_IN;
      1:       return IO_OUT;
      2:       return 16'($urandom_range(256, 16'hFEFF));
      default: return 16'($urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  initial begin
    int          cePulses;
    logic [15:0] ra;
    for (int i = 0; i < DEPTH; i++) begin mMem[i] = 16'h0; mValid[i] = 0; end
    edgeCount = 0; pulses = 0; mCe = 0; mRdata = 0; mRdKnown = 1; mGpio = 0; mErr = 0;

    // Reset state and boot sequence.
    doReset();
    doReset();
    checkOutput("rst_ce", ce, 0);
    checkOutput("rst_cpu_init", cpu_init, 1);
    checkOutput("rst_rdata", rdata, 16'h0);
    checkOutput("rst_gpio", gpio_out, 8'h0);
    checkOutput("rst_err", bus_err, 0);
    cePulses = 0;
    for (int i = 0; i < 40 && cpu_init; i++) begin
      idle(1);
      if (cpu_init && ce) cePulses++;
    end
    checkOutput("init_pulses", cePulses, INIT_CYCLES);
    checkOutput("init_done", cpu_init, 0);

    // Give every RAM word a known value.
    for (int a = 0; a < DEPTH; a++) doWrite(16'(a), 16'($urandom));
    doReset();

    // RAM write then read, and same-edge read-first behaviour.
    doWrite(16'h0060, 16'h1234);
    doRead(16'h0060, 8'h00);
    checkOutput("rd_0060", rdata, 16'h1234);
    doWrite(16'h0061, 16'h0000);
    waitAccess();
    applyStimulus(0, 1, 16'h0061, 1, 16'h0061, 16'h5555, 8'h00);
    checkOutput("rd_first", rdata, 16'h0000);
    doRead(16'h0061, 8'h00);
    checkOutput("rd_after", rdata, 16'h5555);

    // GPIO registers.
    doWrite(IO_OUT, 16'h00A5);
    checkOutput("gpio_out_a5", gpio_out, 8'hA5);
    doRead(IO_IN, 8'h3C);
    checkOutput("rd_gpio_in", rdata, 16'h003C);
    doRead(IO_OUT, 8'h00);
    checkOutput("rd_gpio_out", rdata, 16'h00A5);

    // Reset on the same edge as a RAM write.
    waitAccess();
    applyStimulus(1, 0, 0, 1, 16'h0060, 16'hDEAD, 8'h00);
    checkOutput("rst_wr_init", cpu_init, 1);
    checkOutput("rst_wr_gpio", gpio_out, 8'h00);
    doRead(16'h0060, 8'h00);
    checkOutput("rst_wr_drop", rdata, 16'h1234);

    // Write protection (or its absence).
    doWrite(16'h0010, 16'hBEEF);
    doRead(16'h0010, 8'h00);
    checkOutput("prot_err", bus_err, PROT);
    checkOutput("prot_data", (rdata == 16'hBEEF), !PROT);

    // Unmapped read and write to the GPIO input register.
    doReset();
    doRead(16'h0200, 8'h00);
    checkOutput("rd_unmapped", rdata, 16'h0000);
    checkOutput("err_unmapped", bus_err, 1);
    idle(6);
    checkOutput("err_sticky", bus_err, 1);
    doReset();
    checkOutput("err_cleared", bus_err, 0);
    doWrite(IO_IN, 16'h00FF);
    checkOutput("err_wr_io_in", bus_err, 1);
    doReset();

    // Randomized traffic, including requests outside ce and during boot.
    for (int n = 0; n < 600; n++) begin
      ra = randAddr();
      applyStimulus(($urandom_range(0, 79) == 0), 1'($urandom), ra, 1'($urandom),
                    ($urandom_range(0, 3) == 0) ? ra : randAddr(),
                    16'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
